key_encoder: RTL and testbench
==============================

# key_encoder

Registered 8-to-3 priority encoder for active-low push-buttons: the input-side counterpart of the board's registered 3-to-8 active-low LED decoder. It synchronises and debounces eight switch lines, encodes the highest-index pressed key, and emits a one-cycle press strobe. The enable-gating rule matches the LED decoder, so encoder and decoder can be cascaded on the same bus. It sits between the board buttons and the control logic that drives the `switch`/`enable` inputs of the LED decoder.

## Interface
- `DEBOUNCE_CYCLES`, default 4, number of consecutive cycles a synchronised vector must be stable before acceptance. Must be ≥ 1. The counter is sized `$clog2(DEBOUNCE_CYCLES+1)`.
- `clk` input 1: sole clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `enable` input [2:0]: encoder active only when `enable == 3'd4`.
- `button_n` input [7:0]: raw button lines, active-low (0 = pressed), asynchronous to `clk`.
- `code` output [2:0]: index of the highest-numbered pressed key.
- `gs` output 1: group select; 1 when enabled and at least one key is pressed.
- `eo` output 1: enable-out for cascade; 1 when enabled and no key is pressed.
- `press` output 1: one-cycle strobe marking a new key event.

## Operation
- **Reset (`rst_n` = 0, asynchronous):**
  - `sync1`, `sync2`, `cand` and `stable` are set to 8'hff (all released); `cnt` is set to 0.
  - `code` = 0, `gs` = 0, `eo` = 0, `press` = 0.
  - State is held until the first rising edge after `rst_n` deasserts.
- **Synchroniser:** two-flop chain on `button_n`: `sync1` ← `button_n`, then `sync2` ← `sync1`.
- **Debounce, per edge:**
  - If `sync2` != `cand`: `cand` ← `sync2`, `cnt` ← 0.
  - Else if `cnt` < `DEBOUNCE_CYCLES`-1: `cnt` increments.
  - Else (`cnt` == `DEBOUNCE_CYCLES`-1): `stable` ← `cand`, and `cnt` saturates.
- **Encode, from `stable` and `enable`, all registered:**
  - `hit` = ~`stable`.
  - `next_gs` = (`enable` == 4) && |`hit`.
  - `next_code` = index of the most significant set bit of `hit` when `next_gs`, else 0.
  - `next_eo` = (`enable` == 4) && !|`hit`.
  - `press` ← `next_gs` && (!`gs` || `next_code` != `code`).
- **Priority:** bit 7 is highest. Releasing the highest key while a lower key is still held makes `code` fall to the lower index and pulses `press`.
- **Disabled (`enable` != 4):**
  - `code` = 0, `gs` = 0, `eo` = 0, `press` = 0.
  - The debounce path keeps running, so re-enabling with a key held raises `gs` and pulses `press` one edge later.
- **Release:** when all keys are released, `gs` drops with no `press`; `code` returns to 0.

## Timing
- **Latency:** if `button_n` changes before edge 0 and then holds, `stable` updates at edge `DEBOUNCE_CYCLES`+2 and the outputs at edge `DEBOUNCE_CYCLES`+3. With the default this is edge 7.
- **Glitch rejection:** a change held for fewer than `DEBOUNCE_CYCLES`+1 samples of `sync2` is never accepted into `stable`.
- **Enable path:** `enable` is sampled unsynchronised, so a change affects the outputs at the next edge.
- **`press`:** high for exactly one cycle per accepted event. Back-to-back events that are each debounced produce separate pulses.
- **Reset mid-debounce:** the pending change is discarded. A key still held after reset is re-detected at full latency counted from the first edge after release of reset, and `press` fires.

## Test plan
1. **Reset:** hold `rst_n` = 0 with `button_n` = 8'h00 → `code` = 0, `gs` = 0, `eo` = 0, `press` = 0 immediately, without waiting for a clock edge.
2. **Single key:** `enable` = 4, `button_n` = 8'hdf (key 5) before edge 0 → at edge 7 `code` = 5, `gs` = 1, `eo` = 0, and `press` is high for one cycle. Then release to 8'hff → 7 edges later `gs` = 0, `eo` = 1, no `press`.
3. **Priority:** keys 2 and 6 pressed (8'hbb) → `code` = 6. Then release key 6 (8'hfb) → `code` = 2 with a new `press` pulse.
4. **Glitch:** `button_n` = 8'hfe for 3 cycles, then 8'hff → outputs stay `gs` = 0, `eo` = 1, and `press` never asserts.
5. **Enable gating:** key 3 held and stable, `enable` = 3'd5 → next edge `gs` = 0, `eo` = 0, `code` = 0. Return `enable` to 4 → next edge `code` = 3, `gs` = 1, and `press` pulses.
6. **Reset mid-press:** assert `rst_n` = 0 at edge 4 of a key-7 press, then release it → `gs` rises 7 edges after the first post-reset edge, with `code` = 7 and one `press`.

Source files
------------

// File: rtl/key_encoder.sv
// key_encoder: registered 8-to-3 priority encoder for active-low push-buttons.
// Button lines are synchronised, debounced as a whole vector, then encoded.
// The highest-index pressed key wins. The outputs follow the same enable
// rule as the board's LED decoder (active only when enable == 4), so the two
// blocks can share a bus. The press output is a one-cycle strobe for each
// newly accepted key event.
module key_encoder #(
  parameter int DEBOUNCE_CYCLES = 4  // consecutive stable cycles before acceptance, >= 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] enable,
  input  logic [7:0] button_n,
  output logic [2:0] code,
  output logic       gs,
  output logic       eo,
  output logic       press
);

  localparam int              CNT_W       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]      ENABLE_CODE = 3'd4;
  localparam logic [7:0]      ALL_RELEASED = 8'hff;

  // Input synchroniser and debounce state.
  logic [7:0]       sync1_q;
  logic [7:0]       sync2_q;
  logic [7:0]       cand_q,   cand_d;
  logic [7:0]       stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  // Registered encoder outputs.
  logic [2:0] code_q,  code_d;
  logic       gs_q,    gs_d;
  logic       eo_q,    eo_d;
  logic       press_q, press_d;

  // Encoder intermediates.
  logic [7:0] hit;
  logic       enabled;

  // Debounce: track the latest synchronised vector as a candidate and accept
  // it into stable only after it has held for DEBOUNCE_CYCLES more cycles.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned;
    // otherwise synthesis infers a latch to hold the old value.
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q != cand_q) begin
      // New value seen: restart the stability window.
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q < CNT_LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      // Window complete. The counter saturates, and stable keeps following
      // the candidate for as long as the candidate holds.
      stable_d = cand_q;
    end
  end

  // Two-flop synchroniser followed by the debounce registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= ALL_RELEASED;
      sync2_q  <= ALL_RELEASED;
      cand_q   <= ALL_RELEASED;
      stable_q <= ALL_RELEASED;
      cnt_q    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so that every flop
      // samples the pre-edge value; this is what lets sync1 -> sync2 form a chain.
      sync1_q  <= button_n;
      sync2_q  <= sync1_q;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Priority encode the debounced vector. The press decision compares against
  // the currently registered outputs.
  always_comb begin
    hit     = ~stable_q;
    enabled = (enable == ENABLE_CODE);
    gs_d    = enabled && (|hit);
    eo_d    = enabled && !(|hit);
    code_d  = 3'd0;
    // Ascending scan: the last match is the highest pressed index.
    for (int i = 0; i < 8; i++) begin
      if (hit[i]) begin
        code_d = 3'(i);
      end
    end
    if (!gs_d) begin
      code_d = 3'd0;
    end
    // A new event is either a first press or a change of the winning key.
    // Releasing every key drops gs without producing a strobe.
    press_d = gs_d && (!gs_q || (code_d != code_q));
  end

  // Output registers. The enable input is sampled directly, so an enable
  // change reaches the outputs at the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q  <= 3'd0;
      gs_q    <= 1'b0;
      eo_q    <= 1'b0;
      press_q <= 1'b0;
    end else begin
      code_q  <= code_d;
      gs_q    <= gs_d;
      eo_q    <= eo_d;
      press_q <= press_d;
    end
  end

  assign code  = code_q;
  assign gs    = gs_q;
  assign eo    = eo_q;
  assign press = press_q;

endmodule

// File: tb/tb_key_encoder.sv
// Testbench for key_encoder. Directed scenarios plus a randomized run, checked
// against a reference model. The model decides acceptance with a sliding
// window over the recorded button history.
module tb_key_encoder;

  localparam int D = 4;

  logic       clk;
  logic       rst_n;
  logic [2:0] enable;
  logic [7:0] button_n;
  logic [2:0] code;
  logic       gs;
  logic       eo;
  logic       press;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [7:0] m_stable;
  logic [2:0] m_code;
  logic       m_gs;
  logic       m_eo;
  logic       m_press;
  int         m_edge;
  logic [7:0] hist[$];  // button_n sampled at each edge since reset

  key_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .button_n (button_n),
    .code     (code),
    .gs       (gs),
    .eo       (eo),
    .press    (press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_stable = 8'hff;
    m_code   = 3'd0;
    m_gs     = 1'b0;
    m_eo     = 1'b0;
    m_press  = 1'b0;
    m_edge   = 0;
    hist.delete();
  endtask

  // Vector that the debouncer compares at edge j. The first two edges after
  // reset see the released reset contents of the synchroniser; after that the
  // debouncer sees the button value sampled two edges earlier.
  function automatic logic [7:0] seen_at(int j);
    if (j <= 2) return 8'hff;
    return hist[j-3];
  endfunction

  // Advance the model by one rising edge, using the current inputs.
  task automatic model_edge();
    logic [7:0] hit;
    logic [7:0] v;
    logic       ng;
    logic       ne;
    logic       np;
    logic [2:0] nc;
    logic       all_eq;
    int         k;
    m_edge++;
    k = m_edge;
    hist.push_back(button_n);
    hit = ~m_stable;
    ng  = (enable == 3'd4) && (hit != 8'h00);
    ne  = (enable == 3'd4) && (hit == 8'h00);
    nc  = ng ? 3'($clog2(int'(hit) + 1) - 1) : 3'd0;  // floor(log2(hit))
    np  = ng && (!m_gs || nc != m_code);
    // Accept a vector once D+1 consecutive observations agree.
    v = seen_at(k);
    all_eq = 1'b1;
    for (int j = k - D; j <= k; j++) begin
      if (seen_at(j) != v) all_eq = 1'b0;
    end
    if (all_eq) m_stable = v;
    m_code  = nc;
    m_gs    = ng;
    m_eo    = ne;
    m_press = np;
  endtask

  // One clock: update the model, cross the edge, and return at the falling edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle();
    enable   = 3'd4;
    button_n = 8'hff;
    repeat (12) step();
  endtask

  task automatic release_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    enable   = 3'd4;
    button_n = 8'h00;
    model_reset();
    #1;
    n_cmp++;
    if ({code, gs, eo, press} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_initial: code=%0d gs=%b eo=%b press=%b, want all 0", code, gs, eo, press);
    end
    release_reset();
    repeat (10) step();
    n_cmp++;
    if (gs !== 1'b1 || code !== 3'd7) begin
      n_bad++;
      $display("FAIL reset_pre_async: gs=%b code=%0d, want gs=1 code=7", gs, code);
    end
    // Assert reset in the middle of the cycle; outputs must clear immediately.
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({code, gs, eo, press} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_async: code=%0d gs=%b eo=%b press=%b, want all 0", code, gs, eo, press);
    end
    release_reset();
    settle();
  endtask

  task automatic test_single_key();
    settle();
    button_n = 8'hdf;
    for (int s = 1; s <= 9; s++) begin
      step();
      if (s == 7) begin
        n_cmp++;
        if (gs !== 1'b0 || press !== 1'b0) begin
          n_bad++;
          $display("FAIL single_early: gs=%b press=%b at edge 6, want 0 0", gs, press);
        end
      end
      if (s == 8) begin
        n_cmp++;
        if (code !== 3'd5 || gs !== 1'b1 || eo !== 1'b0 || press !== 1'b1) begin
          n_bad++;
          $display("FAIL single_press: code=%0d gs=%b eo=%b press=%b, want 5 1 0 1", code, gs, eo, press);
        end
      end
      if (s == 9) begin
        n_cmp++;
        if (press !== 1'b0 || gs !== 1'b1) begin
          n_bad++;
          $display("FAIL single_strobe_len: press=%b gs=%b, want 0 1", press, gs);
        end
      end
    end
    button_n = 8'hff;
    for (int s = 1; s <= 8; s++) begin
      step();
      n_cmp++;
      if (press !== 1'b0) begin
        n_bad++;
        $display("FAIL release_no_press: press=%b at step %0d, want 0", press, s);
      end
      if (s == 7) begin
        n_cmp++;
        if (gs !== 1'b1) begin
          n_bad++;
          $display("FAIL release_early: gs=%b at edge 6, want 1", gs);
        end
      end
      if (s == 8) begin
        n_cmp++;
        if (gs !== 1'b0 || eo !== 1'b1 || code !== 3'd0) begin
          n_bad++;
          $display("FAIL release: gs=%b eo=%b code=%0d, want 0 1 0", gs, eo, code);
        end
      end
    end
  endtask

  task automatic test_priority();
    settle();
    button_n = 8'hbb;
    repeat (8) step();
    n_cmp++;
    if (code !== 3'd6 || gs !== 1'b1 || press !== 1'b1) begin
      n_bad++;
      $display("FAIL priority_high: code=%0d gs=%b press=%b, want 6 1 1", code, gs, press);
    end
    repeat (3) step();
    button_n = 8'hfb;
    repeat (7) step();
    n_cmp++;
    if (code !== 3'd6 || press !== 1'b0) begin
      n_bad++;
      $display("FAIL priority_hold: code=%0d press=%b, want 6 0", code, press);
    end
    step();
    n_cmp++;
    if (code !== 3'd2 || gs !== 1'b1 || press !== 1'b1) begin
      n_bad++;
      $display("FAIL priority_fall: code=%0d gs=%b press=%b, want 2 1 1", code, gs, press);
    end
  endtask

  task automatic test_glitch();
    settle();
    button_n = 8'hfe;
    for (int s = 1; s <= 15; s++) begin
      step();
      if (s == 3) button_n = 8'hff;
      n_cmp++;
      if (gs !== 1'b0 || eo !== 1'b1 || press !== 1'b0) begin
        n_bad++;
        $display("FAIL glitch: gs=%b eo=%b press=%b at step %0d, want 0 1 0", gs, eo, press, s);
      end
    end
  endtask

  task automatic test_enable_gating();
    settle();
    button_n = 8'hf7;
    repeat (10) step();
    n_cmp++;
    if (code !== 3'd3 || gs !== 1'b1) begin
      n_bad++;
      $display("FAIL gate_setup: code=%0d gs=%b, want 3 1", code, gs);
    end
    enable = 3'd5;
    step();
    n_cmp++;
    if (code !== 3'd0 || gs !== 1'b0 || eo !== 1'b0 || press !== 1'b0) begin
      n_bad++;
      $display("FAIL gate_off: code=%0d gs=%b eo=%b press=%b, want 0 0 0 0", code, gs, eo, press);
    end
    enable = 3'd4;
    step();
    n_cmp++;
    if (code !== 3'd3 || gs !== 1'b1 || eo !== 1'b0 || press !== 1'b1) begin
      n_bad++;
      $display("FAIL gate_on: code=%0d gs=%b eo=%b press=%b, want 3 1 0 1", code, gs, eo, press);
    end
    step();
    n_cmp++;
    if (press !== 1'b0 || gs !== 1'b1) begin
      n_bad++;
      $display("FAIL gate_strobe_len: press=%b gs=%b, want 0 1", press, gs);
    end
  endtask

  task automatic test_reset_mid_press();
    int presses;
    settle();
    button_n = 8'h7f;
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    model_reset();
    release_reset();
    presses = 0;
    for (int s = 1; s <= 12; s++) begin
      step();
      if (press === 1'b1) presses++;
      if (s == 7) begin
        n_cmp++;
        if (gs !== 1'b0) begin
          n_bad++;
          $display("FAIL rst_mid_early: gs=%b at post-reset edge 6, want 0", gs);
        end
      end
      if (s == 8) begin
        n_cmp++;
        if (gs !== 1'b1 || code !== 3'd7 || press !== 1'b1) begin
          n_bad++;
          $display("FAIL rst_mid_detect: gs=%b code=%0d press=%b, want 1 7 1", gs, code, press);
        end
      end
    end
    n_cmp++;
    if (presses != 1) begin
      n_bad++;
      $display("FAIL rst_mid_press_count: %0d pulses, want 1", presses);
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 3))
          0:       button_n = 8'hff;
          1:       button_n = ~(8'h01 << $urandom_range(0, 7));
          default: button_n = 8'($urandom);
        endcase
        hold = $urandom_range(1, 9);
      end
      hold--;
      if ($urandom_range(0, 19) == 0) begin
        enable = ($urandom_range(0, 1) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({code, gs, eo, press} !== 6'b0) begin
          n_bad++;
          $display("FAIL rand_reset: code=%0d gs=%b eo=%b press=%b, want all 0", code, gs, eo, press);
        end
        release_reset();
      end
      step();
      n_cmp++;
      if (code !== m_code || gs !== m_gs || eo !== m_eo || press !== m_press) begin
        n_bad++;
        $display("FAIL rand_cycle %0d: got code=%0d gs=%b eo=%b press=%b, want code=%0d gs=%b eo=%b press=%b",
                 c, code, gs, eo, press, m_code, m_gs, m_eo, m_press);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_priority();
    test_glitch();
    test_enable_gating();
    test_reset_mid_press();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
